// File: rtl/dmx_frame_scheduler.sv
// Frame scheduler and channel store for the DMX transmitter.
// Paces frame starts with a free-running period timer, arbitrates slot writes
// from two requesters (A/B, round-robin on contention) and serves the
// transmitter through a registered read port.
// Build option: define DMX_DOUBLE_BUFFER_EN for a back/front bank pair with a
// per-frame COPY snapshot; without it a single bank is used and COPY is skipped.
module dmx_frame_scheduler #(
  parameter int unsigned SLOTS        = 512,
  parameter int unsigned FRAME_PERIOD = 44000
) (
  input  logic       dmxclk,
  input  logic       dmxrst_n,
  input  logic       sched_en,
  input  logic       a_req,
  input  logic [8:0] a_addr,
  input  logic [7:0] a_data,
  output logic       a_gnt,
  input  logic       b_req,
  input  logic [8:0] b_addr,
  input  logic [7:0] b_data,
  output logic       b_gnt,
  output logic       tx_start,
  input  logic       tx_done,
  input  logic [8:0] tx_rd_addr,
  output logic [7:0] tx_rd_data,
  output logic [15:0] frame_count,
  output logic       overrun
);

  localparam logic [9:0]  SlotsW     = 10'(SLOTS);
  localparam logic [8:0]  LastSlot   = 9'(SLOTS - 1);
  localparam logic [31:0] PeriodLast = 32'(FRAME_PERIOD - 1);

  typedef enum logic [2:0] {StClear, StWait, StCopy, StStart, StTx} state_e;

  state_e      state_q;
  logic [8:0]  slot_q;        // CLEAR / COPY slot walker
  logic [31:0] timer_q;
  logic        pending_q;     // one buffered expiry that arrived outside WAIT
  logic        overrun_q;
  logic        tx_start_q;
  logic [15:0] frame_count_q;
  logic        rr_ptr_q;      // 0: A wins next contest, 1: B wins
  logic [7:0]  rd_data_q;

  logic        accept;
  logic        contested;
  logic [8:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        wr_en;
  logic        expiry;
  logic        last_slot;

  // Memory write port controls
  logic        front_we;
  logic [8:0]  front_waddr;
  logic [7:0]  front_wdata;
  logic [7:0]  front_mem [512];
`ifdef DMX_DOUBLE_BUFFER_EN
  logic        back_we;
  logic [8:0]  back_waddr;
  logic [7:0]  back_wdata;
  logic [7:0]  back_mem [512];
`endif

  // Grant decode: writes blocked only while clearing; pointer breaks ties
  always_comb begin
    accept    = (state_q != StClear);
    contested = a_req && b_req;
    a_gnt     = accept && a_req && (!b_req || !rr_ptr_q);
    b_gnt     = accept && b_req && (!a_req || rr_ptr_q);
    wr_addr   = a_gnt ? a_addr : b_addr;
    wr_data   = a_gnt ? a_data : b_data;
    // Out-of-range writes are granted but dropped here
    wr_en     = (a_gnt || b_gnt) && ({1'b0, wr_addr} < SlotsW);
    expiry    = (state_q != StClear) && sched_en && (timer_q == PeriodLast);
    last_slot = (slot_q == LastSlot);
  end

  // Frame FSM, timer, pending/overrun tracking and registered outputs
  always_ff @(posedge dmxclk or negedge dmxrst_n) begin
    if (!dmxrst_n) begin
      state_q       <= StClear;
      slot_q        <= 9'd0;
      timer_q       <= 32'd0;
      pending_q     <= 1'b0;
      overrun_q     <= 1'b0;
      tx_start_q    <= 1'b0;
      frame_count_q <= 16'd0;
      rr_ptr_q      <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;

      if (state_q == StClear || !sched_en || expiry) begin
        timer_q <= 32'd0;
      end else begin
        timer_q <= timer_q + 32'd1;
      end

      if (accept && contested) begin
        rr_ptr_q <= !rr_ptr_q;
      end

      if (!sched_en) begin
        pending_q <= 1'b0;
      end else if (expiry && state_q != StWait) begin
        pending_q <= 1'b1;
      end

      if (expiry && state_q != StWait) begin
        overrun_q <= 1'b1;
      end

      unique case (state_q)
        StClear: begin
          slot_q <= slot_q + 9'd1;
          if (last_slot) begin
            slot_q  <= 9'd0;
            state_q <= StWait;
          end
        end
        StWait: begin
          if (expiry || (pending_q && sched_en)) begin
            pending_q <= 1'b0;
`ifdef DMX_DOUBLE_BUFFER_EN
            slot_q    <= 9'd0;
            state_q   <= StCopy;
`else
            state_q       <= StStart;
            tx_start_q    <= 1'b1;
            frame_count_q <= frame_count_q + 16'd1;
`endif
          end
        end
        StCopy: begin
          slot_q <= slot_q + 9'd1;
          if (last_slot) begin
            slot_q        <= 9'd0;
            state_q       <= StStart;
            tx_start_q    <= 1'b1;
            frame_count_q <= frame_count_q + 16'd1;
          end
        end
        StStart: begin
          state_q <= StTx;
        end
        StTx: begin
          if (tx_done) begin
            state_q <= StWait;
          end
        end
        default: begin
          state_q <= StClear;
        end
      endcase
    end
  end

  // Bank write-port steering: CLEAR zeroes, arbiter writes, COPY snapshots
  always_comb begin
    front_we    = 1'b0;
    front_waddr = slot_q;
    front_wdata = 8'h00;
`ifdef DMX_DOUBLE_BUFFER_EN
    back_we     = 1'b0;
    back_waddr  = slot_q;
    back_wdata  = 8'h00;
    if (state_q == StClear) begin
      back_we  = 1'b1;
      front_we = 1'b1;
    end else begin
      back_we     = wr_en;
      back_waddr  = wr_addr;
      back_wdata  = wr_data;
      front_we    = (state_q == StCopy);
      // Reads the pre-write value, so a same-cycle write to this slot stays back-only
      front_wdata = back_mem[slot_q];
    end
`else
    if (state_q == StClear) begin
      front_we = 1'b1;
    end else begin
      front_we    = wr_en;
      front_waddr = wr_addr;
      front_wdata = wr_data;
    end
`endif
  end

  // Slot storage (no reset; contents are initialised by CLEAR)
  always_ff @(posedge dmxclk) begin
    if (front_we) begin
      front_mem[front_waddr] <= front_wdata;
    end
`ifdef DMX_DOUBLE_BUFFER_EN
    if (back_we) begin
      back_mem[back_waddr] <= back_wdata;
    end
`endif
  end

  // Registered read port; out-of-range addresses return zero
  always_ff @(posedge dmxclk or negedge dmxrst_n) begin
    if (!dmxrst_n) begin
      rd_data_q <= 8'h00;
    end else if ({1'b0, tx_rd_addr} < SlotsW) begin
      rd_data_q <= front_mem[tx_rd_addr];
    end else begin
      rd_data_q <= 8'h00;
    end
  end

  assign tx_start    = tx_start_q;
  assign tx_rd_data  = rd_data_q;
  assign frame_count = frame_count_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_dmx_frame_scheduler.sv
// Self-checking bench for dmx_frame_scheduler (either bank configuration).
module tb_dmx_frame_scheduler;

  localparam int SLOTS  = 512;
  localparam int PERIOD = 1200;
`ifdef DMX_DOUBLE_BUFFER_EN
  localparam int COPY_LAT = SLOTS;
`else
  localparam int COPY_LAT = 0;
`endif

  logic       clk;
  logic       rst_n;
  logic       sched_en;
  logic       a_req, b_req, a_gnt, b_gnt;
  logic [8:0] a_addr, b_addr;
  logic [7:0] a_data, b_data;
  logic       tx_start, tx_done;
  logic [8:0] tx_rd_addr;
  logic [7:0] tx_rd_data;
  logic [15:0] frame_count;
  logic       overrun;

  // Small instance for out-of-range address boundaries
  logic       a2_req, a2_gnt, b2_gnt, tx_start2, overrun2;
  logic [8:0] a2_addr, tx_rd_addr2;
  logic [7:0] a2_data, tx_rd_data2;
  logic [15:0] frame_count2;

  dmx_frame_scheduler #(.SLOTS(SLOTS), .FRAME_PERIOD(PERIOD)) dut (
    .dmxclk(clk), .dmxrst_n(rst_n), .sched_en(sched_en),
    .a_req(a_req), .a_addr(a_addr), .a_data(a_data), .a_gnt(a_gnt),
    .b_req(b_req), .b_addr(b_addr), .b_data(b_data), .b_gnt(b_gnt),
    .tx_start(tx_start), .tx_done(tx_done), .tx_rd_addr(tx_rd_addr),
    .tx_rd_data(tx_rd_data), .frame_count(frame_count), .overrun(overrun)
  );

  dmx_frame_scheduler #(.SLOTS(8), .FRAME_PERIOD(40)) dut_small (
    .dmxclk(clk), .dmxrst_n(rst_n), .sched_en(1'b0),
    .a_req(a2_req), .a_addr(a2_addr), .a_data(a2_data), .a_gnt(a2_gnt),
    .b_req(1'b0), .b_addr(9'd0), .b_data(8'h00), .b_gnt(b2_gnt),
    .tx_start(tx_start2), .tx_done(1'b0), .tx_rd_addr(tx_rd_addr2),
    .tx_rd_data(tx_rd_data2), .frame_count(frame_count2), .overrun(overrun2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic rd(input logic [8:0] addr, input logic [7:0] exp, input string name);
    tx_rd_addr = addr;
    @(negedge clk);
    chk(name, {24'd0, tx_rd_data}, {24'd0, exp});
  endtask

  // Returns negedges elapsed until tx_start is seen, or -1 on timeout
  task automatic wait_start(input int max_cyc, output int cyc);
    cyc = 0;
    while (tx_start !== 1'b1 && cyc < max_cyc) begin
      @(negedge clk);
      cyc++;
    end
    if (tx_start !== 1'b1) cyc = -1;
  endtask

  typedef struct {
    logic       a_req;
    logic [8:0] a_addr;
    logic [7:0] a_data;
    logic       b_req;
    logic [8:0] b_addr;
    logic [7:0] b_data;
    logic       exp_a;
    logic       exp_b;
  } vec_t;

  vec_t       vecs [8];
  logic [7:0] model [SLOTS];
  int         bad;
  int         cyc;
  int         starts;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    // Pointer starts at A; every contested grant flips it
    vecs[0] = '{1'b1, 9'd1, 8'h55, 1'b1, 9'd2, 8'hAA, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 9'd0, 8'h00, 1'b1, 9'd2, 8'hAA, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 9'd3, 8'h33, 1'b1, 9'd4, 8'h44, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 9'd3, 8'h33, 1'b0, 9'd0, 8'h00, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 9'd5, 8'h50, 1'b1, 9'd6, 8'h60, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 9'd8, 8'h80, 1'b1, 9'd6, 8'h60, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 9'd8, 8'h80, 1'b0, 9'd0, 8'h00, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 9'd0, 8'h00, 1'b0, 9'd0, 8'h00, 1'b0, 1'b0};
    for (int s = 0; s < SLOTS; s++) model[s] = 8'h00;

    sched_en = 1'b0; tx_done = 1'b0; tx_rd_addr = 9'd0;
    a_req = 1'b0; a_addr = 9'd0; a_data = 8'h00;
    b_req = 1'b0; b_addr = 9'd0; b_data = 8'h00;
    a2_req = 1'b0; a2_addr = 9'd0; a2_data = 8'h00; tx_rd_addr2 = 9'd0;
    rst_n = 1'b1;
    #3 rst_n = 1'b0;

    @(negedge clk);
    chk("reset_tx_start", {31'd0, tx_start}, 0);
    chk("reset_frame_count", {16'd0, frame_count}, 0);
    chk("reset_overrun", {31'd0, overrun}, 0);
    chk("reset_rd_data", {24'd0, tx_rd_data}, 0);
    a_req = 1'b1; a_addr = 9'd3; a_data = 8'hEE;
    b_req = 1'b1; b_addr = 9'd4; b_data = 8'hDD;
    #1 chk("reset_grants", {30'd0, a_gnt, b_gnt}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // CLEAR: grants stay low for SLOTS cycles with both requests held
    bad = 0;
    for (int k = 0; k < SLOTS; k++) begin
      if (a_gnt !== 1'b0 || b_gnt !== 1'b0) bad++;
      @(negedge clk);
    end
    chk("clear_grants_low", bad, 0);
    chk("first_grant_after_clear", {30'd0, a_gnt, b_gnt}, 32'd2);
    a_req = 1'b0; b_req = 1'b0;
    rd(9'd0, 8'h00, "rd_slot0_after_clear");
    rd(9'd511, 8'h00, "rd_slot511_after_clear");
    chk("frame_count_after_clear", {16'd0, frame_count}, 0);

    // Out-of-range write is granted; reads beyond SLOTS return zero
    a2_req = 1'b1; a2_addr = 9'd9; a2_data = 8'h77;
    #1 chk("small_oob_grant", {31'd0, a2_gnt}, 1);
    @(negedge clk);
    a2_req = 1'b0; tx_rd_addr2 = 9'd9;
    @(negedge clk);
    chk("small_oob_read", {24'd0, tx_rd_data2}, 0);
    tx_rd_addr2 = 9'd8;
    @(negedge clk);
    chk("small_first_oob_read", {24'd0, tx_rd_data2}, 0);
    tx_rd_addr2 = 9'd7;
    @(negedge clk);
    chk("small_last_slot_clear", {24'd0, tx_rd_data2}, 0);

    // Arbitration table
    for (int i = 0; i < 8; i++) begin
      a_req = vecs[i].a_req; a_addr = vecs[i].a_addr; a_data = vecs[i].a_data;
      b_req = vecs[i].b_req; b_addr = vecs[i].b_addr; b_data = vecs[i].b_data;
      #1;
      chk($sformatf("arb_a_gnt[%0d]", i), {31'd0, a_gnt}, {31'd0, vecs[i].exp_a});
      chk($sformatf("arb_b_gnt[%0d]", i), {31'd0, b_gnt}, {31'd0, vecs[i].exp_b});
      if (vecs[i].exp_a) model[vecs[i].a_addr] = vecs[i].a_data;
      if (vecs[i].exp_b) model[vecs[i].b_addr] = vecs[i].b_data;
      @(negedge clk);
    end
    a_req = 1'b0; b_req = 1'b0;

    // Frame 1: expiry-to-start latency
    sched_en = 1'b1;
    wait_start(PERIOD + COPY_LAT + 10, cyc);
    chk("enable_to_tx_start", cyc, PERIOD + COPY_LAT);
    chk("frame_count_1", {16'd0, frame_count}, 1);
    @(negedge clk);
    chk("tx_start_one_cycle", {31'd0, tx_start}, 0);
    for (int s = 1; s <= 9; s++) rd(9'(s), model[s], $sformatf("rd_frame1_slot%0d", s));

    // Write during TX: same-cycle read sees old value
    a_req = 1'b1; a_addr = 9'd5; a_data = 8'h11; tx_rd_addr = 9'd5;
    #1 chk("tx_write_grant", {31'd0, a_gnt}, 1);
    @(negedge clk);
    a_req = 1'b0;
    chk("rd_same_cycle_old", {24'd0, tx_rd_data}, 32'h50);
    @(negedge clk);
`ifdef DMX_DOUBLE_BUFFER_EN
    chk("rd_snapshot_held", {24'd0, tx_rd_data}, 32'h50);
`else
    chk("rd_after_write", {24'd0, tx_rd_data}, 32'h11);
`endif
    b_req = 1'b1; b_addr = 9'd9; b_data = 8'h99;
    #1 chk("tx_write_grant_b", {31'd0, b_gnt}, 1);
    @(negedge clk);
    b_req = 1'b0;
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;

    // Frame 2: writes made during frame 1 are now visible
    chk("no_overrun_yet", {31'd0, overrun}, 0);
    wait_start(2 * PERIOD + COPY_LAT, cyc);
    chk("frame2_started", {31'd0, tx_start}, 1);
    chk("frame_count_2", {16'd0, frame_count}, 2);
    rd(9'd5, 8'h11, "rd_frame2_slot5");
    rd(9'd9, 8'h99, "rd_frame2_slot9");

    // Hold TX past an expiry: overrun, then pending frame follows tx_done
    repeat (PERIOD + 5) @(negedge clk);
    chk("overrun_set", {31'd0, overrun}, 1);
    chk("frame_count_held_in_tx", {16'd0, frame_count}, 2);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    wait_start(COPY_LAT + 10, cyc);
    chk("pending_to_tx_start", cyc, 1 + COPY_LAT);
    chk("frame_count_3", {16'd0, frame_count}, 3);

    // Drop enable in TX: frame finishes, no further starts
    @(negedge clk);
    sched_en = 1'b0;
    repeat (5) @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    starts = 0;
    repeat (3 * PERIOD) begin
      if (tx_start === 1'b1) starts++;
      @(negedge clk);
    end
    chk("no_start_when_disabled", starts, 0);
    chk("frame_count_still_3", {16'd0, frame_count}, 3);

    // Reset mid-frame (inside COPY for the double-bank build)
    sched_en = 1'b1;
    repeat (PERIOD - 5 + COPY_LAT / 2) @(negedge clk);
    chk("frame_count_before_reset", {16'd0, frame_count}, 3);
    chk("overrun_sticky", {31'd0, overrun}, 1);
    a_req = 1'b1; a_addr = 9'd3; a_data = 8'hEE;
    rst_n = 1'b0;
    #1;
    chk("midreset_tx_start", {31'd0, tx_start}, 0);
    chk("midreset_frame_count", {16'd0, frame_count}, 0);
    chk("midreset_overrun", {31'd0, overrun}, 0);
    chk("midreset_rd_data", {24'd0, tx_rd_data}, 0);
    chk("midreset_grant", {31'd0, a_gnt}, 0);
    a_req = 1'b0; sched_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (SLOTS) begin
      if (tx_start !== 1'b0) bad++;
      @(negedge clk);
    end
    chk("no_start_during_clear", bad, 0);
    bad = 0;
    for (int s = 0; s < SLOTS; s++) begin
      tx_rd_addr = 9'(s);
      @(negedge clk);
      if (tx_rd_data !== 8'h00) bad++;
    end
    chk("all_slots_zero_after_reclear", bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
